ks10_bus_arb: RTL

Parametrised multi-master backplane bus controller for the KS10 FPGA, the successor to the fixed single-master CPU request path and its separate NXM/NXD timeout logic. It arbitrates `NCHAN` bus masters (CPU, console, UBA DMA, ...) onto the single KS10 backplane request/ack bus using round-robin priority. It runs one transaction at a time, returns read data with a one-cycle acknowledge, and reports non-existent memory/device per channel on timeout.

---
 rtl/ks10_bus_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/ks10_bus_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ks10_bus_pkg.sv
// Shared definitions for the KS10 backplane bus controller: FSM state encoding,
// bus widths and the address flag bit positions also used by the NXM/NXD logic.
package ks10_bus_pkg;

    localparam int KS10_AW = 36;
    localparam int KS10_DW = 36;

    // Address flag bits within the 36-bit address-and-flags word
    localparam int KS10_FLAG_RD = 33;
    localparam int KS10_FLAG_WR = 31;
    localparam int KS10_FLAG_IO = 29;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } busarb_state_t;

    function automatic logic is_io_access(input logic [KS10_AW-1:0] addr);
        return addr[KS10_FLAG_IO];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: the first requester at or after
// ptr_i (wrapping) wins; reports it one-hot and as an index.
module rr_arbiter
    import ks10_bus_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int IW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic [NCHAN-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [NCHAN-1:0] grant_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    logic [IW-1:0] win_idx;
    logic          win_any;

    generate
        if (NCHAN == 1) begin : g_single
            logic unused_ptr;
            assign unused_ptr = ptr_i[0];
            assign win_idx    = '0;
            assign win_any    = req_i[0];
        end else begin : g_multi
            // Walk offsets from farthest to nearest so the channel closest to ptr_i wins
            always_comb begin
                logic [IW-1:0] idx;
                idx     = '0;
                win_idx = '0;
                win_any = 1'b0;
                for (int k = NCHAN - 1; k >= 0; k--) begin
                    idx = IW'((int'(ptr_i) + k) % NCHAN);
                    if (req_i[idx]) begin
                        win_idx = idx;
                        win_any = 1'b1;
                    end
                end
            end
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_onehot
            assign grant_o[gi] = win_any && (win_idx == IW'(gi));
        end
    endgenerate

    assign idx_o = win_idx;
    assign any_o = win_any;

endmodule

// File: rtl/ks10_bus_arb.sv
// Round-robin multi-master KS10 backplane bus controller, one transaction at a time.
// Define KS10_BUSARB_TIMEOUT_EN to build the NXM timeout counter, FAIL path and nxmO/nxmADDRO.
module ks10_bus_arb
    import ks10_bus_pkg::*;
#(
    parameter int NCHAN   = 4,
    parameter int TIMEOUT = 127,
    parameter int AW      = KS10_AW,
    parameter int DW      = KS10_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCHAN-1:0]    reqIN,
    input  logic [NCHAN*AW-1:0] addrIN,
    input  logic [NCHAN*DW-1:0] dataIN,
    output logic [NCHAN-1:0]    grantO,
    output logic [NCHAN-1:0]    waitO,
    output logic [NCHAN-1:0]    ackO,
    output logic [NCHAN-1:0]    nxmO,
    output logic [DW-1:0]       dataO,
    output logic                busREQO,
    output logic [AW-1:0]       busADDRO,
    output logic [DW-1:0]       busDATAO,
    input  logic                busACKI,
    input  logic [DW-1:0]       busDATAI,
    output logic [AW-1:0]       nxmADDRO
);

    localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [AW-1:0] addr_ch [NCHAN];
    logic [DW-1:0] data_ch [NCHAN];

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_unpack
            assign addr_ch[gi] = addrIN[gi*AW +: AW];
            assign data_ch[gi] = dataIN[gi*DW +: DW];
        end
    endgenerate

    busarb_state_t    state_q;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q;
    logic [NCHAN-1:0] grant_q;
    logic [NCHAN-1:0] ack_q;
    logic [DW-1:0]    data_q;
    logic             busreq_q;
    logic [AW-1:0]    busaddr_q;
    logic [DW-1:0]    busdata_q;

    logic [NCHAN-1:0] arb_onehot;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(
        .NCHAN (NCHAN),
        .IW    (IW)
    ) u_arb (
        .req_i   (reqIN),
        .ptr_i   (ptr_q),
        .grant_o (arb_onehot),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        ptr_d = '0;
        if (NCHAN > 1 && owner_q != IW'(NCHAN - 1)) begin
            ptr_d = owner_q + IW'(1);
        end
    end

`ifdef KS10_BUSARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NCHAN-1:0] nxm_q;
    logic [AW-1:0]    nxmaddr_q;

    assign cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            data_q    <= '0;
            busreq_q  <= 1'b0;
            busaddr_q <= '0;
            busdata_q <= '0;
`ifdef KS10_BUSARB_TIMEOUT_EN
            cnt_q     <= '0;
            nxm_q     <= '0;
            nxmaddr_q <= '0;
`endif
        end else begin
            busreq_q <= 1'b0;
            ack_q    <= '0;
`ifdef KS10_BUSARB_TIMEOUT_EN
            nxm_q    <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        owner_q   <= arb_idx;
                        grant_q   <= arb_onehot;
                        busaddr_q <= addr_ch[arb_idx];
                        busdata_q <= data_ch[arb_idx];
                        busreq_q  <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
`ifdef KS10_BUSARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Ack takes priority over a timeout expiring in the same cycle
                    if (busACKI) begin
                        data_q  <= busDATAI;
                        ack_q   <= grant_q;
                        state_q <= ST_DONE;
                    end
`ifdef KS10_BUSARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT)) begin
                        nxm_q     <= grant_q;
                        nxmaddr_q <= busaddr_q;
                        state_q   <= ST_FAIL;
                    end else begin
                        cnt_q <= cnt_d;
                    end
`endif
                end
                ST_DONE, ST_FAIL: begin
                    ptr_q   <= ptr_d;
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef KS10_BUSARB_TIMEOUT_EN
    assign nxmO     = nxm_q;
    assign nxmADDRO = nxmaddr_q;
`else
    assign nxmO     = '0;
    assign nxmADDRO = '0;
`endif

    assign grantO   = grant_q;
    assign ackO     = ack_q;
    assign dataO    = data_q;
    assign busREQO  = busreq_q;
    assign busADDRO = busaddr_q;
    assign busDATAO = busdata_q;
    assign waitO    = reqIN & ~(ackO | nxmO);

endmodule
